instr_mem_loader: RTL and testbench

Parametrised instruction memory with an integrated, button-driven word loader. The operator enters each instruction as MSB-first chunks on a narrow data input, and each debounced button press commits one chunk. A complete word is written to memory atomically once its last chunk arrives. In run mode the processor fetch stage reads the memory through a registered read port with a valid strobe. Addresses never loaded read back as zero (NOP).

---
 rtl/instr_mem_loader_pkg.sv | 18 +
 rtl/instr_mem_loader_btn_edge_sync.sv | 34 +++
 rtl/instr_mem_loader.sv | 134 +++++++++++++
 tb/tb_instr_mem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: mode encodings,
// FSM state type and the chunks-per-word helper.
package instr_mem_loader_pkg;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FULL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int instr_w, input int chunk_w);
        return (instr_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/instr_mem_loader_btn_edge_sync.sv
// Two-flop synchroniser for the raw push-button followed by an edge register
// that yields a single-cycle pulse per rising edge.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic btn_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = button;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign btn_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a button-driven MSB-first chunk loader and a
// registered fetch port that is active only in run mode.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int CHUNK_W = 6,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_enable,
    input  logic               button,
    input  logic [CHUNK_W-1:0] data_in,
    input  logic               mode,
    input  logic               read_en,
    input  logic [ADDR_W-1:0]  read_address,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               out_valid,
    output logic [1:0]         chunk_idx,
    output logic [ADDR_W:0]    load_count,
    output logic               load_full
);

    localparam int NCHUNK = calc_nchunk(INSTR_W, CHUNK_W);
    localparam int LAST_W = INSTR_W - (NCHUNK - 1) * CHUNK_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      LAST_IDX  = 2'(NCHUNK - 1);

    logic [INSTR_W-1:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [1:0]         chunk_idx_q, chunk_idx_d;
    logic [INSTR_W-1:0] assembly_q, assembly_d;
    logic [ADDR_W:0]    load_count_q, load_count_d;
    logic [INSTR_W-1:0] instruction_out_q, instruction_out_d;
    logic               out_valid_q, out_valid_d;

    logic               btn_pulse;
    logic               mem_we;
    logic [INSTR_W-1:0] wdata;
    logic [INSTR_W-1:0] mem_rdata;
    int                 shamt;

    btn_edge_sync u_btn_edge_sync (
        .clk       (clk),
        .reset     (reset),
        .button    (button),
        .btn_pulse (btn_pulse)
    );

    assign wdata     = assembly_q | INSTR_W'(data_in[LAST_W-1:0]);
    assign mem_rdata = mem[read_address];
    assign shamt     = INSTR_W - CHUNK_W - int'(chunk_idx_q) * CHUNK_W;

    // A mode change takes priority over a pending button pulse in the same cycle.
    always_comb begin
        state_d           = state_q;
        chunk_idx_d       = chunk_idx_q;
        assembly_d        = assembly_q;
        load_count_d      = load_count_q;
        instruction_out_d = instruction_out_q;
        out_valid_d       = out_valid_q;
        mem_we            = 1'b0;
        if (clk_enable) begin
            out_valid_d = 1'b0;
            unique case (state_q)
                S_LOAD, S_FULL: begin
                    if (mode == MODE_RUN) begin
                        state_d     = S_RUN;
                        chunk_idx_d = 2'd0;
                        assembly_d  = '0;
                    end else if (state_q == S_LOAD && btn_pulse) begin
                        if (chunk_idx_q == LAST_IDX) begin
                            mem_we       = 1'b1;
                            load_count_d = load_count_q + 1'b1;
                            chunk_idx_d  = 2'd0;
                            assembly_d   = '0;
                            if (load_count_q + 1'b1 == DEPTH_CNT) begin
                                state_d = S_FULL;
                            end
                        end else begin
                            assembly_d  = assembly_q | (INSTR_W'(data_in) << shamt);
                            chunk_idx_d = chunk_idx_q + 2'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (mode == MODE_LOAD) begin
                        state_d = load_full ? S_FULL : S_LOAD;
                    end
                    if (read_en) begin
                        out_valid_d       = 1'b1;
                        instruction_out_d = ({1'b0, read_address} < load_count_q) ? mem_rdata : '0;
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_LOAD;
            chunk_idx_q       <= 2'd0;
            assembly_q        <= '0;
            load_count_q      <= '0;
            instruction_out_q <= '0;
            out_valid_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            chunk_idx_q       <= chunk_idx_d;
            assembly_q        <= assembly_d;
            load_count_q      <= load_count_d;
            instruction_out_q <= instruction_out_d;
            out_valid_q       <= out_valid_d;
        end
    end

    // Array is never cleared; stale contents are hidden by the load_count range check.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[load_count_q[ADDR_W-1:0]] <= wdata;
        end
    end

    assign instruction_out = instruction_out_q;
    assign out_valid       = out_valid_q;
    assign chunk_idx       = chunk_idx_q;
    assign load_count      = load_count_q;
    assign load_full       = (load_count_q == DEPTH_CNT);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader at default parameters
// (16-bit words, 6-bit chunks, 64 entries).
module tb_instr_mem_loader;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        button;
    logic [5:0]  data_in;
    logic        mode;
    logic        read_en;
    logic [5:0]  read_address;
    logic [15:0] instruction_out;
    logic        out_valid;
    logic [1:0]  chunk_idx;
    logic [6:0]  load_count;
    logic        load_full;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_mem_loader #(
        .INSTR_W (16),
        .CHUNK_W (6),
        .ADDR_W  (6)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable      (clk_enable),
        .button          (button),
        .data_in         (data_in),
        .mode            (mode),
        .read_en         (read_en),
        .read_address    (read_address),
        .instruction_out (instruction_out),
        .out_valid       (out_valid),
        .chunk_idx       (chunk_idx),
        .load_count      (load_count),
        .load_full       (load_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        clk_enable = 1'b1;
        button     = 1'b0;
        data_in    = '0;
        mode       = 1'b0;
        read_en    = 1'b0;
        read_address = '0;
        cycles(2);
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic press(input logic [5:0] chunk);
        data_in = chunk;
        button  = 1'b1;
        cycles(4);
        button  = 1'b0;
        cycles(3);
    endtask

    task automatic load_word(input logic [15:0] w);
        press(w[15:10]);
        press(w[9:4]);
        press({2'b00, w[3:0]});
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (instruction_out !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_instr got %h want 0000", instruction_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (chunk_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_chunk got %0d want 0", chunk_idx); end
        n_cmp++; if (load_count !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", load_count); end
        n_cmp++; if (load_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full got %b want 0", load_full); end
    endtask

    task automatic test_basic_load();
        do_reset();
        press(6'h10);
        n_cmp++; if (chunk_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL basic_chunk1 got %0d want 1", chunk_idx); end
        press(6'h04);
        press(6'h01);
        n_cmp++; if (load_count !== 7'd1) begin n_fail++; $display("[TB] FAIL basic_count got %0d want 1", load_count); end
        n_cmp++; if (chunk_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL basic_chunk0 got %0d want 0", chunk_idx); end
        mode = 1'b1;
        cycles(1);
        read_en = 1'b1; read_address = 6'd0;
        cycles(1);
        read_en = 1'b0;
        n_cmp++; if (instruction_out !== 16'h4041) begin n_fail++; $display("[TB] FAIL basic_read got %h want 4041", instruction_out); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid got %b want 1", out_valid); end
        cycles(1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_strobe got %b want 0", out_valid); end
        n_cmp++; if (instruction_out !== 16'h4041) begin n_fail++; $display("[TB] FAIL basic_hold got %h want 4041", instruction_out); end
    endtask

    task automatic test_partial_discard();
        do_reset();
        press(6'h3F);
        press(6'h3F);
        n_cmp++; if (chunk_idx !== 2'd2) begin n_fail++; $display("[TB] FAIL partial_chunk2 got %0d want 2", chunk_idx); end
        mode = 1'b1;
        cycles(1);
        n_cmp++; if (chunk_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL partial_drop got %0d want 0", chunk_idx); end
        mode = 1'b0;
        cycles(1);
        load_word(16'h0002);
        n_cmp++; if (load_count !== 7'd1) begin n_fail++; $display("[TB] FAIL partial_count got %0d want 1", load_count); end
        mode = 1'b1;
        cycles(1);
        read_en = 1'b1; read_address = 6'd0;
        cycles(1);
        read_en = 1'b0;
        n_cmp++; if (instruction_out !== 16'h0002) begin n_fail++; $display("[TB] FAIL partial_read got %h want 0002", instruction_out); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_word(16'h1234);
        load_word(16'h5678);
        load_word(16'h9ABC);
        n_cmp++; if (load_count !== 7'd3) begin n_fail++; $display("[TB] FAIL b2b_count got %0d want 3", load_count); end
        mode = 1'b1;
        cycles(1);
        read_en = 1'b1; read_address = 6'd0;
        cycles(1);
        n_cmp++; if (instruction_out !== 16'h1234 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_r0 got %h/%b want 1234/1", instruction_out, out_valid); end
        read_address = 6'd1;
        cycles(1);
        n_cmp++; if (instruction_out !== 16'h5678 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_r1 got %h/%b want 5678/1", instruction_out, out_valid); end
        read_address = 6'd2;
        cycles(1);
        n_cmp++; if (instruction_out !== 16'h9ABC || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_r2 got %h/%b want 9abc/1", instruction_out, out_valid); end
        read_address = 6'd10;
        cycles(1);
        read_en = 1'b0;
        n_cmp++; if (instruction_out !== 16'h0000 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_read got %h/%b want 0000/1", instruction_out, out_valid); end
        cycles(1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle got %b want 0", out_valid); end
        mode = 1'b0;
        cycles(1);
        read_en = 1'b1; read_address = 6'd0;
        cycles(1);
        read_en = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL load_mode_read got %b want 0", out_valid); end
    endtask

    task automatic test_button_hold();
        do_reset();
        data_in = 6'h05;
        button  = 1'b1;
        cycles(50);
        n_cmp++; if (chunk_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL hold_chunk got %0d want 1", chunk_idx); end
        button = 1'b0;
        cycles(3);
        clk_enable = 1'b0;
        button     = 1'b1;
        cycles(6);
        clk_enable = 1'b1;
        cycles(4);
        n_cmp++; if (chunk_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL disabled_press got %0d want 1", chunk_idx); end
        button = 1'b0;
        cycles(3);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            load_word(16'(i));
        end
        n_cmp++; if (load_count !== 7'd64) begin n_fail++; $display("[TB] FAIL full_count got %0d want 64", load_count); end
        n_cmp++; if (load_full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_flag got %b want 1", load_full); end
        load_word(16'hFFFF);
        n_cmp++; if (load_count !== 7'd64) begin n_fail++; $display("[TB] FAIL full_sat got %0d want 64", load_count); end
        n_cmp++; if (chunk_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL full_chunk got %0d want 0", chunk_idx); end
        mode = 1'b1;
        cycles(1);
        read_en = 1'b1; read_address = 6'd0;
        cycles(1);
        n_cmp++; if (instruction_out !== 16'h0000) begin n_fail++; $display("[TB] FAIL full_nowrap got %h want 0000", instruction_out); end
        read_address = 6'd63;
        cycles(1);
        read_en = 1'b0;
        n_cmp++; if (instruction_out !== 16'h003F) begin n_fail++; $display("[TB] FAIL full_last got %h want 003f", instruction_out); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        load_word(16'hABCD);
        press(6'h2A);
        press(6'h3C);
        n_cmp++; if (chunk_idx !== 2'd2) begin n_fail++; $display("[TB] FAIL mid_chunk got %0d want 2", chunk_idx); end
        reset = 1'b1;
        mode  = 1'b1;
        cycles(1);
        reset = 1'b0;
        n_cmp++; if (chunk_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL mid_rst_chunk got %0d want 0", chunk_idx); end
        n_cmp++; if (load_count !== 7'd0) begin n_fail++; $display("[TB] FAIL mid_rst_count got %0d want 0", load_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valid got %b want 0", out_valid); end
        cycles(1);
        read_en = 1'b1; read_address = 6'd0;
        cycles(1);
        read_en = 1'b0;
        n_cmp++; if (instruction_out !== 16'h0000 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_read got %h/%b want 0000/1", instruction_out, out_valid); end
    endtask

    initial begin
        $display("[TB] starting instr_mem_loader bench");
        test_reset();
        test_basic_load();
        test_partial_discard();
        test_back_to_back();
        test_button_hold();
        test_full();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
